// File: rtl/exp_return_pkg.sv
// rtl/exp_return_pkg.sv - exception codes, trap sequencer states and CSR constants for exp_return
package exp_return_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    EXP_IMISALIGN = 4'd0,
    EXP_IFAULT    = 4'd1,
    EXP_ILLEGAL   = 4'd2,
    EXP_BREAK     = 4'd3,
    EXP_LMISALIGN = 4'd4,
    EXP_LFAULT    = 4'd5,
    EXP_SMISALIGN = 4'd6,
    EXP_SFAULT    = 4'd7,
    EXP_ECALL_M   = 4'd11
  } ExpCode_t;

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_TVAL,
    S_STATUS,
    R_STATUS
  } ExpRetState_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

endpackage

// File: rtl/exp_return.sv
// rtl/exp_return.sv - trap entry/return CSR write sequencer; EXP_TVAL_EN adds the mtval write
module exp_return
  import exp_return_pkg::*;
#(
  parameter int ADDR = ADDR_W,
  parameter int DATA = DATA_W
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            commit_exp_,
  input  ExpCode_t        commit_exp_code,
  input  logic [ADDR-1:0] commit_pc,
  input  logic [DATA-1:0] commit_tval,
  input  logic            commit_mret_,
  input  logic [DATA-1:0] creg_status,
  input  logic [DATA-1:0] creg_epc,
  output logic            creg_we_,
  output logic [11:0]     creg_waddr,
  output logic [DATA-1:0] creg_wdata,
  output logic            exp_busy_,
  output logic            exp_done_,
  output logic            ret_valid_,
  output logic [ADDR-1:0] ret_pc
);

  ExpRetState_t    state, nxt_state;
  ExpCode_t        code_q, nxt_code;
  logic            nxt_we_, nxt_busy_, nxt_done_, nxt_ret_valid_;
  logic [11:0]     nxt_waddr;
  logic [DATA-1:0] nxt_wdata;
  logic [ADDR-1:0] nxt_ret_pc;
  logic            unused_bits;

`ifdef EXP_TVAL_EN
  logic [DATA-1:0] tval_q, nxt_tval;
`endif

  assign unused_bits = ^{creg_epc, commit_tval};

  function automatic logic [DATA-1:0] entry_status(input logic [DATA-1:0] s);
    logic [DATA-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP +: 2] = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA-1:0] ret_status(input logic [DATA-1:0] s);
    logic [DATA-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  // Outputs are registered: each transition precomputes the write for the state being entered.
  always_comb begin
    nxt_state      = state;
    nxt_code       = code_q;
    nxt_we_        = 1'b1;
    nxt_waddr      = '0;
    nxt_wdata      = '0;
    nxt_done_      = 1'b1;
    nxt_ret_valid_ = 1'b1;
    nxt_ret_pc     = '0;
`ifdef EXP_TVAL_EN
    nxt_tval       = tval_q;
`endif
    case (state)
      IDLE: begin
        if (!commit_exp_) begin
          nxt_state = S_EPC;
          nxt_code  = commit_exp_code;
`ifdef EXP_TVAL_EN
          nxt_tval  = commit_tval;
`endif
          nxt_we_   = 1'b0;
          nxt_waddr = CSR_MEPC;
          nxt_wdata = DATA'({commit_pc[ADDR-1:2], 2'b00});
        end else if (!commit_mret_) begin
          nxt_state      = R_STATUS;
          nxt_we_        = 1'b0;
          nxt_waddr      = CSR_MSTATUS;
          nxt_wdata      = ret_status(creg_status);
          nxt_ret_valid_ = 1'b0;
          nxt_ret_pc     = {creg_epc[ADDR-1:2], 2'b00};
        end
      end
      S_EPC: begin
        nxt_state = S_CAUSE;
        nxt_we_   = 1'b0;
        nxt_waddr = CSR_MCAUSE;
        nxt_wdata = DATA'(code_q);
      end
`ifdef EXP_TVAL_EN
      S_CAUSE: begin
        nxt_state = S_TVAL;
        nxt_we_   = 1'b0;
        nxt_waddr = CSR_MTVAL;
        nxt_wdata = tval_q;
      end
`else
      S_CAUSE: begin
        nxt_state = S_STATUS;
        nxt_we_   = 1'b0;
        nxt_waddr = CSR_MSTATUS;
        nxt_wdata = entry_status(creg_status);
        nxt_done_ = 1'b0;
      end
`endif
      S_TVAL: begin
        nxt_state = S_STATUS;
        nxt_we_   = 1'b0;
        nxt_waddr = CSR_MSTATUS;
        nxt_wdata = entry_status(creg_status);
        nxt_done_ = 1'b0;
      end
      default: nxt_state = IDLE;
    endcase
    nxt_busy_ = (nxt_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state      <= IDLE;
      code_q     <= EXP_IMISALIGN;
      creg_we_   <= 1'b1;
      creg_waddr <= '0;
      creg_wdata <= '0;
      exp_busy_  <= 1'b1;
      exp_done_  <= 1'b1;
      ret_valid_ <= 1'b1;
      ret_pc     <= '0;
`ifdef EXP_TVAL_EN
      tval_q     <= '0;
`endif
    end else begin
      state      <= nxt_state;
      code_q     <= nxt_code;
      creg_we_   <= nxt_we_;
      creg_waddr <= nxt_waddr;
      creg_wdata <= nxt_wdata;
      exp_busy_  <= nxt_busy_;
      exp_done_  <= nxt_done_;
      ret_valid_ <= nxt_ret_valid_;
      ret_pc     <= nxt_ret_pc;
`ifdef EXP_TVAL_EN
      tval_q     <= nxt_tval;
`endif
    end
  end

endmodule

// File: tb/tb_exp_return.sv
// tb/tb_exp_return.sv - directed self-checking bench for exp_return (follows EXP_TVAL_EN)
module tb_exp_return;
  import exp_return_pkg::*;

`ifdef EXP_TVAL_EN
  localparam int ENTRY_N = 4;
`else
  localparam int ENTRY_N = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_;
  logic        commit_exp_;
  ExpCode_t    commit_exp_code;
  logic [31:0] commit_pc;
  logic [31:0] commit_tval;
  logic        commit_mret_;
  logic [31:0] creg_status;
  logic [31:0] creg_epc;
  logic        creg_we_;
  logic [11:0] creg_waddr;
  logic [31:0] creg_wdata;
  logic        exp_busy_;
  logic        exp_done_;
  logic        ret_valid_;
  logic [31:0] ret_pc;

  int n_total = 0;
  int n_pass  = 0;

  exp_return #(.ADDR(32), .DATA(32)) dut (
    .clk(clk), .reset_(reset_),
    .commit_exp_(commit_exp_), .commit_exp_code(commit_exp_code),
    .commit_pc(commit_pc), .commit_tval(commit_tval), .commit_mret_(commit_mret_),
    .creg_status(creg_status), .creg_epc(creg_epc),
    .creg_we_(creg_we_), .creg_waddr(creg_waddr), .creg_wdata(creg_wdata),
    .exp_busy_(exp_busy_), .exp_done_(exp_done_),
    .ret_valid_(ret_valid_), .ret_pc(ret_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] entry_addr(input int c);
    case (c)
      1:       return CSR_MEPC;
      2:       return CSR_MCAUSE;
      3:       return (ENTRY_N == 4) ? CSR_MTVAL : CSR_MSTATUS;
      default: return CSR_MSTATUS;
    endcase
  endfunction

  initial begin
    reset_ = 1'b0; commit_exp_ = 1'b0; commit_mret_ = 1'b1;
    commit_exp_code = EXP_BREAK; commit_pc = 32'h0; commit_tval = 32'h0;
    creg_status = 32'h0; creg_epc = 32'h0;

    // reset held with an exception pending
    tick(); tick(); tick();
    chk("rst_we", creg_we_, 1'b1);
    chk("rst_busy", exp_busy_, 1'b1);
    chk("rst_done", exp_done_, 1'b1);
    chk("rst_retv", ret_valid_, 1'b1);
    chk("rst_waddr", creg_waddr, 12'h0);
    chk("rst_wdata", creg_wdata, 32'h0);
    chk("rst_retpc", ret_pc, 32'h0);
    reset_ = 1'b1; commit_exp_ = 1'b1;
    tick();
    chk("idle_we", creg_we_, 1'b1);

    // trap entry
    commit_exp_ = 1'b0; commit_exp_code = EXP_BREAK;
    commit_pc = 32'h0000cafe; commit_tval = 32'h1234; creg_status = 32'h8;
    tick();
    commit_exp_ = 1'b1;
    chk("e_epc_we", creg_we_, 1'b0);
    chk("e_epc_addr", creg_waddr, CSR_MEPC);
    chk("e_epc_data", creg_wdata, 32'hcafc);
    chk("e_busy", exp_busy_, 1'b0);
    chk("e_done_early", exp_done_, 1'b1);
    tick();
    chk("e_cause_addr", creg_waddr, CSR_MCAUSE);
    chk("e_cause_data", creg_wdata, 32'd3);
`ifdef EXP_TVAL_EN
    tick();
    chk("e_tval_addr", creg_waddr, CSR_MTVAL);
    chk("e_tval_data", creg_wdata, 32'h1234);
`endif
    tick();
    chk("e_stat_addr", creg_waddr, CSR_MSTATUS);
    chk("e_stat_data", creg_wdata, 32'h1880);
    chk("e_done", exp_done_, 1'b0);
    chk("e_retv", ret_valid_, 1'b1);
    tick();
    chk("e_idle_we", creg_we_, 1'b1);
    chk("e_idle_busy", exp_busy_, 1'b1);
    chk("e_idle_done", exp_done_, 1'b1);

    // mret
    commit_mret_ = 1'b0; creg_epc = 32'h00001002; creg_status = 32'h80;
    tick();
    commit_mret_ = 1'b1;
    chk("r_we", creg_we_, 1'b0);
    chk("r_addr", creg_waddr, CSR_MSTATUS);
    chk("r_data", creg_wdata, 32'h88);
    chk("r_valid", ret_valid_, 1'b0);
    chk("r_pc", ret_pc, 32'h1000);
    chk("r_done", exp_done_, 1'b1);
    tick();
    chk("r_valid_end", ret_valid_, 1'b1);
    chk("r_we_end", creg_we_, 1'b1);

    // exception and mret together: exception wins
    commit_exp_ = 1'b0; commit_mret_ = 1'b0; commit_exp_code = EXP_ECALL_M;
    commit_pc = 32'h2000; commit_tval = 32'h0; creg_status = 32'h8;
    tick();
    commit_exp_ = 1'b1; commit_mret_ = 1'b1;
    for (int c = 1; c <= ENTRY_N; c++) begin
      chk($sformatf("both_retv_c%0d", c), ret_valid_, 1'b1);
      chk($sformatf("both_addr_c%0d", c), creg_waddr, entry_addr(c));
      if (c == 1) chk("both_epc", creg_wdata, 32'h2000);
      if (c == 2) chk("both_cause", creg_wdata, 32'd11);
      if (c == ENTRY_N) chk("both_done", exp_done_, 1'b0);
      tick();
    end
    chk("both_retv_after", ret_valid_, 1'b1);

    // request during the sequence is ignored, then accepted after exp_done_
    commit_exp_ = 1'b0; commit_exp_code = EXP_ILLEGAL; commit_pc = 32'h3000;
    tick();
    commit_exp_ = 1'b1;
    chk("n_a_epc", creg_wdata, 32'h3000);
    tick();
    commit_exp_ = 1'b0; commit_exp_code = EXP_ECALL_M; commit_pc = 32'h4000;
    chk("n_busy_c2", exp_busy_, 1'b0);
    for (int c = 3; c <= ENTRY_N; c++) begin
      tick();
      chk($sformatf("n_busy_c%0d", c), exp_busy_, 1'b0);
      chk($sformatf("n_addr_c%0d", c), creg_waddr, entry_addr(c));
    end
    chk("n_a_done", exp_done_, 1'b0);
    tick();
    chk("n_idle_busy", exp_busy_, 1'b1);
    tick();
    commit_exp_ = 1'b1;
    chk("n_b_addr", creg_waddr, CSR_MEPC);
    chk("n_b_epc", creg_wdata, 32'h4000);
    for (int c = 2; c <= ENTRY_N; c++) tick();
    chk("n_b_done", exp_done_, 1'b0);
    tick();

    // reset in the state just before the mstatus write
    commit_exp_ = 1'b0; commit_exp_code = EXP_BREAK; commit_pc = 32'h5000;
    tick();
    commit_exp_ = 1'b1;
    for (int c = 2; c < ENTRY_N; c++) tick();
    chk("x_pre_addr", creg_waddr, entry_addr(ENTRY_N - 1));
    reset_ = 1'b0;
    tick();
    chk("x_we", creg_we_, 1'b1);
    chk("x_done", exp_done_, 1'b1);
    chk("x_busy", exp_busy_, 1'b1);
    chk("x_waddr", creg_waddr, 12'h0);
    reset_ = 1'b1;
    tick();
    chk("x_post_we", creg_we_, 1'b1);
    chk("x_post_done", exp_done_, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exp_return.md
Name: exp_return

Overview:
- Trap-entry/trap-return sequencer placed beside exp_manage in the commit stage.
- On a committed exception it writes mepc, mcause, mtval and mstatus into the CSR file, one write per cycle.
- On a committed mret it restores mstatus and redirects fetch to mepc.
- It is the return end of the trap interface. exp_manage supplies the handler PC; exp_return saves state on entry and produces the return PC on exit.

Parameters:
- ADDR, `AddrWidth, instruction address width
- DATA, `DataWidth, CSR/data width (>= ADDR)

Ports:
- clk  in  1  clock
- reset_  in  1  synchronous active-low reset
- commit_exp_  in  1  active-low; exception committed this cycle
- commit_exp_code  in  ExpCode_t  cause of the committed exception
- commit_pc  in  ADDR  PC of the faulting or mret instruction
- commit_tval  in  DATA  trap value
- commit_mret_  in  1  active-low; mret committed this cycle
- creg_status  in  DATA  current mstatus
- creg_epc  in  DATA  current mepc
- creg_we_  out  1  active-low CSR write strobe
- creg_waddr  out  12  CSR address (csr.svh constants)
- creg_wdata  out  DATA  CSR write data
- exp_busy_  out  1  active-low; sequencer busy, commit must stall
- exp_done_  out  1  active-low one-cycle pulse; entry sequence complete
- ret_valid_  out  1  active-low one-cycle pulse; redirect to ret_pc
- ret_pc  out  ADDR  return target

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. While reset_ is low the state is IDLE and outputs are:
  - creg_we_, exp_busy_, exp_done_, ret_valid_ all 1
  - creg_waddr = 0, creg_wdata = 0, ret_pc = 0
- States: IDLE, S_EPC, S_CAUSE, S_TVAL, S_STATUS, R_STATUS.
- IDLE:
  - If commit_exp_ = 0, latch pc/code/tval and go to S_EPC. An exception has priority; a simultaneous mret is dropped.
  - Else if commit_mret_ = 0, latch creg_epc and go to R_STATUS.
  - Commit inputs are sampled only in IDLE. In every other state they are ignored and exp_busy_ = 0.
- Entry sequence, one registered write per state:
  - S_EPC: addr = mepc, data = zero-extended pc with bits[1:0] = 0.
  - S_CAUSE: addr = mcause, data = {1'b0, zero-extended code}.
  - S_TVAL: addr = mtval, data = tval.
  - S_STATUS: addr = mstatus, data = creg_status with MPIE(7) = MIE(3), MIE(3) = 0, MPP(12:11) = 2'b11. exp_done_ = 0 in the same cycle. Next state is IDLE.
  - Latency: request at cycle 0 gives writes in cycles 1 to 4. exp_done_ is at cycle 4. A new request is accepted from cycle 5.
- Return sequence, R_STATUS:
  - Write mstatus with MIE = MPIE and MPIE = 1.
  - ret_valid_ = 0.
  - ret_pc = latched epc[ADDR-1:0] with bits[1:0] = 0.
  - Next state is IDLE. Total latency is 1 cycle.
- creg_we_ is 0 only in the write states.
- exp_done_ and ret_valid_ are never asserted in the same cycle.
- Reset mid-sequence returns to IDLE next edge. CSR writes already performed are not rolled back and no pulse is emitted.
- Back-to-back requests: an exception committed in the cycle after exp_done_ is accepted normally, so trap nesting is supported.

Optional Feature:
- Macro: EXP_TVAL_EN.
- Defined: the S_TVAL state exists and entry takes 4 write cycles.
- Undefined: S_CAUSE goes directly to S_STATUS and commit_tval is unused. Entry takes 3 cycles, with exp_done_ at cycle 3. mtval is never written.

Decomposition:
- exception.svh: ExpCode_t (existing) and a new ExpRetState_t enum for the states.
- csr.svh: the mepc, mcause, mtval and mstatus addresses plus the MIE/MPIE/MPP bit-position constants.
- No sub-module: a single FSM with a registered write port.

Test Plan:
- Reset with commit_exp_ = 0 held → state stays IDLE, all active-low outputs 1, no CSR writes.
- commit_exp_ = 0, code = EXP_BREAK, pc = 0x0000cafe, tval = 0x1234, status = 0x8 → writes in order:
  - mepc = 0xcafc
  - mcause = EXP_BREAK
  - mtval = 0x1234
  - mstatus = 0x1880
  - exp_done_ at cycle 4
- commit_mret_ = 0, epc = 0x00001002, status = 0x80 → next cycle: mstatus write = 0x88, ret_valid_ = 0, ret_pc = 0x1000.
- commit_exp_ and commit_mret_ both 0 → entry sequence only, ret_valid_ never asserted.
- New exp request during S_CAUSE → ignored, exp_busy_ = 0 throughout. The same request re-presented after exp_done_ is accepted.
- reset_ = 0 in S_TVAL → IDLE next cycle, no S_STATUS write, no exp_done_. Run with EXP_TVAL_EN undefined → mtval never written, exp_done_ at cycle 3.
